// File: rtl/vga_scan_gen_if.sv
// Scan-generator bundle: the pixel-clock enable in, and coordinates, strobes and pipeline-aligned sync/DE out.
interface vga_scan_gen_if #(
    parameter int unsigned CW = 12
);
    logic          pix_ce;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic          vga_hsync;
    logic          vga_vsync;
    logic          vga_de;

    modport master (
        input  pix_ce,
        output x, y, active, line_start, frame_start, vga_hsync, vga_vsync, vga_de
    );

    modport slave (
        output pix_ce,
        input  x, y, active, line_start, frame_start, vga_hsync, vga_vsync, vga_de
    );
endinterface

// File: rtl/vga_scan_gen.sv
// Parametrised VGA scan generator on a pix_ce-qualified system clock.
// Produces x/y and strobes undelayed; sync/DE are delayed PIPE_DLY ticks to line up with the graphics pipeline.
module vga_scan_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned PIPE_DLY = 2,
    parameter int unsigned CW       = 12
) (
    input  logic              clk_in,
    input  logic              resetn,
    vga_scan_gen_if.master    bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned T_MAX   = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time guard against timings the counters or delay line cannot represent
    if ((H_FP == 0) || (H_SYNC == 0) || (H_BP == 0) ||
        (V_FP == 0) || (V_SYNC == 0) || (V_BP == 0) ||
        (PIPE_DLY > 15) ||
        ((CW < 32) && ((64'd1 << CW) < 64'(T_MAX)))) begin : g_bad_param
        $error("vga_scan_gen: illegal timing parameters");
    end

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;
    logic          w_active;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic          w_h_zero;

    // Raster counters; v advances only when h wraps
    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (bus.pix_ce) begin
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CW'(1);
            end
        end
    end

    assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_raw = ((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    assign w_vs_raw = ((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    assign w_h_zero = (r_h_cnt == '0);

    assign bus.x           = r_h_cnt;
    assign bus.y           = r_v_cnt;
    assign bus.active      = w_active;
    // Strobes are tick-qualified and forced low while reset is held
    assign bus.line_start  = resetn && bus.pix_ce && w_h_zero;
    assign bus.frame_start = resetn && bus.pix_ce && w_h_zero && (r_v_cnt == '0);

    if (PIPE_DLY == 0) begin : g_nodly
        // Zero-latency path still shows inactive levels during reset
        assign bus.vga_hsync = resetn ? w_hs_raw : ~HS_POL;
        assign bus.vga_vsync = resetn ? w_vs_raw : ~VS_POL;
        assign bus.vga_de    = resetn && w_active;
    end else begin : g_dly
        logic [PIPE_DLY-1:0] r_hs_sr;
        logic [PIPE_DLY-1:0] r_vs_sr;
        logic [PIPE_DLY-1:0] r_de_sr;

        // Shift in the raw decode on each pixel tick; oldest stage drives the pins
        always_ff @(posedge clk_in or negedge resetn) begin
            if (!resetn) begin
                r_hs_sr <= {PIPE_DLY{~HS_POL}};
                r_vs_sr <= {PIPE_DLY{~VS_POL}};
                r_de_sr <= '0;
            end else if (bus.pix_ce) begin
                r_hs_sr <= PIPE_DLY'({r_hs_sr, w_hs_raw});
                r_vs_sr <= PIPE_DLY'({r_vs_sr, w_vs_raw});
                r_de_sr <= PIPE_DLY'({r_de_sr, w_active});
            end
        end

        assign bus.vga_hsync = r_hs_sr[PIPE_DLY-1];
        assign bus.vga_vsync = r_vs_sr[PIPE_DLY-1];
        assign bus.vga_de    = r_de_sr[PIPE_DLY-1];
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: three configurations checked every cycle against a behavioural scoreboard,
// plus count vectors and hand-written reset/latency/line-length sequences.
module tb_vga_scan_gen;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        bit hpol, vpol;
        int dly;
    } cfg_t;

    typedef struct {
        int        h, v;
        bit [15:0] hq, vq, dq;
    } model_t;

    typedef struct packed {
        logic [11:0] x, y;
        logic active, ls, fs, hs, vs, de;
    } obs_t;

    typedef struct {
        int ncyc;
        bit tog;
        int ls, fs, de, hs, vs;
    } vec_t;

    logic clk, resetn, pix_ce;
    int   n_cmp, n_err;
    int   cnt_ls, cnt_fs, cnt_de, cnt_hs, cnt_vs;

    cfg_t   cfg[3];
    model_t mdl[3];
    obs_t   sb_q[$];
    obs_t   act[3];
    vec_t   vecs[5];

    vga_scan_gen_if #(.CW(12)) if0 ();
    vga_scan_gen_if #(.CW(12)) if1 ();
    vga_scan_gen_if #(.CW(12)) if2 ();
    assign if0.pix_ce = pix_ce;
    assign if1.pix_ce = pix_ce;
    assign if2.pix_ce = pix_ce;

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0), .CW(12))
        u_dut0 (.clk_in(clk), .resetn(resetn), .bus(if0.master));

    vga_scan_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(3), .CW(12))
        u_dut1 (.clk_in(clk), .resetn(resetn), .bus(if1.master));

    vga_scan_gen u_dut2 (.clk_in(clk), .resetn(resetn), .bus(if2.master));

    assign act[0] = {if0.x, if0.y, if0.active, if0.line_start, if0.frame_start, if0.vga_hsync, if0.vga_vsync, if0.vga_de};
    assign act[1] = {if1.x, if1.y, if1.active, if1.line_start, if1.frame_start, if1.vga_hsync, if1.vga_vsync, if1.vga_de};
    assign act[2] = {if2.x, if2.y, if2.active, if2.line_start, if2.frame_start, if2.vga_hsync, if2.vga_vsync, if2.vga_de};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit raw_hs(cfg_t c, int h);
        return (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
    endfunction

    function automatic bit raw_vs(cfg_t c, int v);
        return (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
    endfunction

    function automatic model_t m_reset(cfg_t c);
        model_t m;
        m.h  = 0;
        m.v  = 0;
        m.hq = {16{~c.hpol}};
        m.vq = {16{~c.vpol}};
        m.dq = '0;
        return m;
    endfunction

    function automatic model_t m_step(cfg_t c, model_t m);
        model_t n = m;
        bit act_now = (m.h < c.ha) && (m.v < c.va);
        n.hq = {m.hq[14:0], raw_hs(c, m.h)};
        n.vq = {m.vq[14:0], raw_vs(c, m.v)};
        n.dq = {m.dq[14:0], act_now};
        n.h  = m.h + 1;
        if (n.h == c.ha + c.hfp + c.hsw + c.hbp) begin
            n.h = 0;
            n.v = m.v + 1;
            if (n.v == c.va + c.vfp + c.vsw + c.vbp) n.v = 0;
        end
        return n;
    endfunction

    function automatic obs_t predict(cfg_t c, model_t m, bit ce, bit rstn);
        obs_t e;
        e.x      = 12'(m.h);
        e.y      = 12'(m.v);
        e.active = (m.h < c.ha) && (m.v < c.va);
        e.ls     = ce && rstn && (m.h == 0);
        e.fs     = e.ls && (m.v == 0);
        if (c.dly == 0) begin
            e.hs = rstn ? raw_hs(c, m.h) : ~c.hpol;
            e.vs = rstn ? raw_vs(c, m.v) : ~c.vpol;
            e.de = rstn && e.active;
        end else begin
            e.hs = m.hq[c.dly-1];
            e.vs = m.vq[c.dly-1];
            e.de = m.dq[c.dly-1];
        end
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Push predictions for this cycle, sample the DUTs 1 time unit later and compare
    task automatic sb_cmp(input bit ce);
        obs_t e;
        for (int d = 0; d < 3; d++) sb_q.push_back(predict(cfg[d], mdl[d], ce, resetn));
        #1;
        for (int d = 0; d < 3; d++) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (act[d] !== e) begin
                n_err++;
                $display("FAIL sb_dut%0d t=%0t got x=%0d y=%0d act/ls/fs/hs/vs/de=%b%b%b%b%b%b expected x=%0d y=%0d act/ls/fs/hs/vs/de=%b%b%b%b%b%b",
                         d, $time, act[d].x, act[d].y, act[d].active, act[d].ls, act[d].fs, act[d].hs, act[d].vs, act[d].de,
                         e.x, e.y, e.active, e.ls, e.fs, e.hs, e.vs, e.de);
            end
        end
    endtask

    task automatic tick(input bit ce);
        @(negedge clk);
        pix_ce = ce;
        sb_cmp(ce);
        if (act[0].ls === 1'b1) cnt_ls++;
        if (act[0].fs === 1'b1) cnt_fs++;
        if (ce) begin
            if (act[0].de === 1'b1) cnt_de++;
            if (act[0].hs === 1'b1) cnt_hs++;
            if (act[0].vs === 1'b1) cnt_vs++;
        end
        if (ce && resetn) for (int d = 0; d < 3; d++) mdl[d] = m_step(cfg[d], mdl[d]);
    endtask

    task automatic models_reset();
        for (int d = 0; d < 3; d++) mdl[d] = m_reset(cfg[d]);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        resetn = 1'b0;
        models_reset();
        tick(1'b1);
        @(negedge clk);
        pix_ce = 1'b0;
        resetn = 1'b1;
    endtask

    initial begin
        int first, second, nls, guard;
        n_cmp  = 0;
        n_err  = 0;
        pix_ce = 1'b0;
        resetn = 1'b0;
        cfg[0] = '{ha:8, hfp:2, hsw:3, hbp:3, va:4, vfp:1, vsw:2, vbp:1, hpol:1'b1, vpol:1'b1, dly:0};
        cfg[1] = '{ha:8, hfp:2, hsw:3, hbp:3, va:4, vfp:1, vsw:2, vbp:1, hpol:1'b0, vpol:1'b1, dly:3};
        cfg[2] = '{ha:800, hfp:40, hsw:128, hbp:88, va:600, vfp:1, vsw:4, vbp:23, hpol:1'b1, vpol:1'b1, dly:2};
        // {cycles, toggle ce, line_starts, frame_starts, de/hs/vs counted on tick cycles}
        vecs[0] = '{ncyc:128, tog:1'b0, ls:8,  fs:1, de:32, hs:24, vs:32};
        vecs[1] = '{ncyc:256, tog:1'b1, ls:8,  fs:1, de:32, hs:24, vs:32};
        vecs[2] = '{ncyc:16,  tog:1'b0, ls:1,  fs:1, de:8,  hs:3,  vs:0};
        vecs[3] = '{ncyc:96,  tog:1'b0, ls:6,  fs:1, de:32, hs:18, vs:16};
        vecs[4] = '{ncyc:272, tog:1'b0, ls:17, fs:3, de:72, hs:51, vs:64};
        models_reset();

        for (int k = 0; k < 5; k++) begin
            rst_pulse();
            cnt_ls = 0; cnt_fs = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
            for (int i = 0; i < vecs[k].ncyc; i++) tick(vecs[k].tog ? (i % 2 == 0) : 1'b1);
            chk($sformatf("vec%0d_line_starts", k),  cnt_ls, vecs[k].ls);
            chk($sformatf("vec%0d_frame_starts", k), cnt_fs, vecs[k].fs);
            chk($sformatf("vec%0d_de_ticks", k),     cnt_de, vecs[k].de);
            chk($sformatf("vec%0d_hs_ticks", k),     cnt_hs, vecs[k].hs);
            chk($sformatf("vec%0d_vs_ticks", k),     cnt_vs, vecs[k].vs);
        end

        // Delayed, active-low hsync: reset levels for 3 ticks, de at h=3, hsync low at h=13..15
        rst_pulse();
        for (int h = 0; h < 16; h++) begin
            tick(1'b1);
            chk($sformatf("dly3_x_h%0d", h), int'(act[1].x), h);
            chk($sformatf("dly3_hsync_h%0d", h), int'(act[1].hs), (h >= 13) ? 0 : 1);
            if (h < 3) chk($sformatf("dly3_de_h%0d", h), int'(act[1].de), 0);
            if (h == 3) chk("dly3_de_first", int'(act[1].de), 1);
        end

        // Asynchronous reset mid-cycle at h=5, v=2
        rst_pulse();
        guard = 0;
        while (!(mdl[0].h == 5 && mdl[0].v == 2) && guard < 200) begin
            tick(1'b1);
            guard++;
        end
        chk("midrst_reached", guard, 37);
        @(posedge clk);
        #1;
        chk("midrst_pre_x", int'(act[0].x), 5);
        chk("midrst_pre_y", int'(act[0].y), 2);
        #1;
        resetn = 1'b0;
        models_reset();
        sb_cmp(pix_ce);
        chk("midrst_de_now", int'(act[1].de), 0);
        chk("midrst_hs_now", int'(act[1].hs), 1);
        @(negedge clk);
        pix_ce = 1'b0;
        resetn = 1'b1;
        tick(1'b1);
        chk("midrst_frame_start", int'(act[0].fs), 1);
        chk("midrst_x0", int'(act[0].x), 0);
        chk("midrst_y0", int'(act[0].y), 0);

        // Default 800x600 timing: line length 1056
        rst_pulse();
        first = -1; second = -1; nls = 0;
        for (int t = 0; t < 2113; t++) begin
            tick(1'b1);
            if (act[2].ls === 1'b1) begin
                if (nls == 0) first = t;
                else if (nls == 1) second = t;
                nls++;
                if (nls == 3) chk("dflt_y_line2", int'(act[2].y), 2);
            end
        end
        chk("dflt_line_count", nls, 3);
        chk("dflt_h_total", second - first, 1056);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
